// File: rtl/tpu_pkg.sv
// Shared types and helpers for the tile-scheduling datapath.
package tpu_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_FINISH  = 3'd6
    } sched_state_e;

    // Default widths of MMU partial results and of the accumulators.
    localparam int DEF_RES_W = 8;
    localparam int DEF_ACC_W = 16;

    // Signed add of two 32-bit operands, clamped to the range of a
    // width-bit signed number. Callers sign-extend their operands to 32
    // bits and truncate the result back to width bits (width < 32).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 width
    );
        logic signed [32:0] sum;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        sum   = {a[31], a} + {b[31], b};
        max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (width - 1));
        if (sum > max_v) begin
            return max_v[31:0];
        end else if (sum < min_v) begin
            return min_v[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/tile_accumulator.sv
// Four-lane output-tile accumulator: captures one set of MMU partials,
// folds it into the running sums, and presents one lane for draining.
module tile_accumulator
    import tpu_pkg::*;
#(
    parameter int RES_W = DEF_RES_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,     // latch c00..c11 this cycle
    input  logic             accumulate,  // fold captured partials into acc
    input  logic             first,       // k==0: load instead of add
    input  logic [RES_W-1:0] c00,
    input  logic [RES_W-1:0] c01,
    input  logic [RES_W-1:0] c10,
    input  logic [RES_W-1:0] c11,
    input  logic [1:0]       sel,         // lane order 00, 01, 10, 11
    output logic [ACC_W-1:0] acc_out
);

    logic [RES_W-1:0] part_q [4];
    logic [ACC_W-1:0] acc_q  [4];
    logic [ACC_W-1:0] acc_d  [4];
    logic [31:0]      p_ext  [4];
    logic [31:0]      a_ext  [4];

    // Hold the partials from the mmu_done cycle so the add happens one
    // cycle later, off the MMU output timing path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                part_q[n] <= '0;
            end
        end else if (capture) begin
            part_q[0] <= c00;
            part_q[1] <= c01;
            part_q[2] <= c10;
            part_q[3] <= c11;
        end
    end

    // Sign-extend both operands and either load (k==0) or saturate-add.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            p_ext[n] = {{(32 - RES_W){part_q[n][RES_W-1]}}, part_q[n]};
            a_ext[n] = {{(32 - ACC_W){acc_q[n][ACC_W-1]}}, acc_q[n]};
            if (first) begin
                acc_d[n] = ACC_W'(p_ext[n]);
            end else begin
                acc_d[n] = ACC_W'(sat_add(a_ext[n], p_ext[n], ACC_W));
            end
        end
    end

    // Accumulator registers; left untouched outside the ACCUM cycle so an
    // aborted job leaves its partial sums visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                acc_q[n] <= '0;
            end
        end else if (accumulate) begin
            for (int n = 0; n < 4; n++) begin
                acc_q[n] <= acc_d[n];
            end
        end
    end

    assign acc_out = acc_q[sel];

endmodule

// File: rtl/mmu_tile_scheduler.sv
// Tile scheduler for the 2x2 systolic MMU: walks (i,j,k) over 2x2 tiles,
// requests each A/B tile load, launches the MMU, accumulates partials and
// streams the finished output tile one element at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its payload stable until that edge; valid does
// not depend combinationally on ready. This applies to ld_* and out_*.
module mmu_tile_scheduler
    import tpu_pkg::*;
#(
    parameter int MAX_TILES = 4,
    parameter int IDX_W     = $clog2(MAX_TILES),
    parameter int RES_W     = DEF_RES_W,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W:0]   num_tiles,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic [IDX_W-1:0] ld_a_row,
    output logic [IDX_W-1:0] ld_a_col,
    output logic [IDX_W-1:0] ld_b_row,
    output logic [IDX_W-1:0] ld_b_col,
    output logic             mmu_start,
    input  logic             mmu_done,
    input  logic [RES_W-1:0] c00,
    input  logic [RES_W-1:0] c01,
    input  logic [RES_W-1:0] c10,
    input  logic [RES_W-1:0] c11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [IDX_W:0]   out_row,
    output logic [IDX_W:0]   out_col
);

    localparam logic [IDX_W:0] MAX_T = (IDX_W + 1)'(MAX_TILES);

    sched_state_e     state_q;
    sched_state_e     state_d;

    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W:0]   n_q;
    logic [1:0]       word_q;
    logic             err_q;

    logic             num_ok;
    logic             abort_hit;
    logic [IDX_W:0]   n_m1;
    logic             last_k;
    logic             last_j;
    logic             last_i;
    logic             out_fire;
    logic             last_word;

    assign num_ok    = (num_tiles != '0) && (num_tiles <= MAX_T);
    assign abort_hit = abort && (state_q != ST_IDLE);
    assign n_m1      = n_q - (IDX_W + 1)'(1);
    assign last_k    = ({1'b0, k_q} == n_m1);
    assign last_j    = ({1'b0, j_q} == n_m1);
    assign last_i    = ({1'b0, i_q} == n_m1);
    assign out_fire  = (state_q == ST_DRAIN) && out_ready;
    assign last_word = (word_q == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other event, including a
    // handshake completing in the same cycle.
    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = num_ok ? ST_LOAD : ST_FINISH;
                    end
                end
                ST_LOAD: begin
                    if (ld_ready) begin
                        state_d = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_d = ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (mmu_done) begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    state_d = last_k ? ST_DRAIN : ST_LOAD;
                end
                ST_DRAIN: begin
                    if (out_ready && last_word) begin
                        state_d = (last_i && last_j) ? ST_FINISH : ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode: every control output is a pure function of state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        ld_valid  = 1'b0;
        mmu_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_LOAD:   ld_valid  = 1'b1;
            ST_LAUNCH: mmu_start = 1'b1;
            ST_DRAIN:  out_valid = 1'b1;
            ST_FINISH: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
            end
        endcase
    end

    // Loop counters: k inner, j middle, i outer; word walks the four
    // elements of the output tile during DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            n_q    <= '0;
            word_q <= '0;
            err_q  <= 1'b0;
        end else if (!abort_hit) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_ok) begin
                            n_q    <= num_tiles;
                            i_q    <= '0;
                            j_q    <= '0;
                            k_q    <= '0;
                            word_q <= '0;
                            err_q  <= 1'b0;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (!last_k) begin
                        k_q <= k_q + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (last_word) begin
                            word_q <= '0;
                            k_q    <= '0;
                            if (last_j) begin
                                j_q <= '0;
                                i_q <= i_q + IDX_W'(1);
                            end else begin
                                j_q <= j_q + IDX_W'(1);
                            end
                        end else begin
                            word_q <= word_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tile indices come straight from the counters, which only move
    // outside LOAD, so they are stable across a stalled load request.
    assign ld_a_row = i_q;
    assign ld_a_col = k_q;
    assign ld_b_row = k_q;
    assign ld_b_col = j_q;

    // Element coordinates: row = 2i + r, col = 2j + c with word = {r, c}.
    assign out_row = {i_q, word_q[1]};
    assign out_col = {j_q, word_q[0]};

    tile_accumulator #(
        .RES_W (RES_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    ((state_q == ST_COMPUTE) && mmu_done && !abort),
        .accumulate ((state_q == ST_ACCUM) && !abort),
        .first      (k_q == '0),
        .c00        (c00),
        .c01        (c01),
        .c10        (c10),
        .c11        (c11),
        .sel        (word_q),
        .acc_out    (out_data)
    );

endmodule

// File: tb/tb_mmu_tile_scheduler.sv
// Directed bench for mmu_tile_scheduler with a behavioural memory/MMU
// environment; a second instance with a 9-bit accumulator shares all
// inputs so saturation can be observed on the same traffic.
module tb_mmu_tile_scheduler;

    localparam int MAX_TILES = 4;
    localparam int IDX_W     = 2;
    localparam int RES_W     = 8;
    localparam int ACC_W     = 16;
    localparam int SAT_ACC_W = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    // ---------------- DUT signals ----------------
    logic             start, abort, ld_ready, out_ready, mmu_done;
    logic [IDX_W:0]   num_tiles;
    logic [RES_W-1:0] c00, c01, c10, c11;
    logic             busy, done, err, ld_valid, mmu_start, out_valid;
    logic [IDX_W-1:0] ld_a_row, ld_a_col, ld_b_row, ld_b_col;
    logic [ACC_W-1:0] out_data;
    logic [IDX_W:0]   out_row, out_col;

    logic             s_busy, s_done, s_err, s_ld_valid, s_mmu_start, s_out_valid;
    logic [IDX_W-1:0] s_ld_a_row, s_ld_a_col, s_ld_b_row, s_ld_b_col;
    logic [SAT_ACC_W-1:0] s_out_data;
    logic [IDX_W:0]   s_out_row, s_out_col;

    mmu_tile_scheduler #(.MAX_TILES(MAX_TILES), .RES_W(RES_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_a_row(ld_a_row), .ld_a_col(ld_a_col), .ld_b_row(ld_b_row), .ld_b_col(ld_b_col),
        .mmu_start(mmu_start), .mmu_done(mmu_done),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col)
    );

    mmu_tile_scheduler #(.MAX_TILES(MAX_TILES), .RES_W(RES_W), .ACC_W(SAT_ACC_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .abort(abort),
        .busy(s_busy), .done(s_done), .err(s_err),
        .ld_valid(s_ld_valid), .ld_ready(ld_ready),
        .ld_a_row(s_ld_a_row), .ld_a_col(s_ld_a_col), .ld_b_row(s_ld_b_row), .ld_b_col(s_ld_b_col),
        .mmu_start(s_mmu_start), .mmu_done(mmu_done),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_row(s_out_row), .out_col(s_out_col)
    );

    // ---------------- MMU model: done pulse 2 cycles after launch ----------------
    logic model_done  = 1'b0;
    logic inject_done = 1'b0;
    int   mmu_cnt     = 0;
    assign mmu_done = model_done | inject_done;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (mmu_start) begin
            mmu_cnt = 2;
        end else if (mmu_cnt > 0) begin
            mmu_cnt--;
            if (mmu_cnt == 0) model_done = 1'b1;
        end
    end

    // ---------------- monitors ----------------
    logic [7:0]  load_q[$];
    logic [21:0] got_q[$];
    logic [15:0] got_s_q[$];
    int          starts      = 0;
    int          last_hs_cyc = 0;

    always @(negedge clk) begin
        if (ld_valid && ld_ready) load_q.push_back({ld_a_row, ld_a_col, ld_b_row, ld_b_col});
        if (mmu_start) starts++;
        if (out_valid && out_ready) begin
            got_q.push_back({out_row, out_col, out_data});
            got_s_q.push_back({{(16 - SAT_ACC_W){s_out_data[SAT_ACC_W-1]}}, s_out_data});
            last_hs_cyc = cyc_n;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int               n;
        logic [3:0][7:0]  p;
        logic [3:0][15:0] e;
        logic [3:0][15:0] es;
        logic             er;
    } vec_t;

    logic [7:0]  exp_ld_q[$];
    logic [21:0] exp_q[$];
    logic [15:0] exp_s_q[$];

    int errors = 0;
    int checks = 0;
    int done_cyc;
    logic done_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc_n);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc_n);
    endtask

    function automatic vec_t mk(input int n, input int p0, input int p1, input int p2, input int p3,
                                input int e0, input int e1, input int e2, input int e3,
                                input int s0, input int s1, input int s2, input int s3,
                                input logic er);
        vec_t v;
        v.n = n;
        v.p[0] = 8'(p0);   v.p[1] = 8'(p1);   v.p[2] = 8'(p2);   v.p[3] = 8'(p3);
        v.e[0] = 16'(e0);  v.e[1] = 16'(e1);  v.e[2] = 16'(e2);  v.e[3] = 16'(e3);
        v.es[0] = 16'(s0); v.es[1] = 16'(s1); v.es[2] = 16'(s2); v.es[3] = 16'(s3);
        v.er = er;
        return v;
    endfunction

    // Expected loads in (i,j,k) order and expected words in (i,j,r,c) order.
    function automatic void build_exp(input vec_t v);
        exp_ld_q.delete();
        exp_q.delete();
        exp_s_q.delete();
        if (v.er) return;
        for (int i = 0; i < v.n; i++)
            for (int j = 0; j < v.n; j++) begin
                for (int k = 0; k < v.n; k++)
                    exp_ld_q.push_back({2'(i), 2'(k), 2'(k), 2'(j)});
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++) begin
                        exp_q.push_back({3'(2 * i + r), 3'(2 * j + c), v.e[2 * r + c]});
                        exp_s_q.push_back(v.es[2 * r + c]);
                    end
            end
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, "_loads"}, load_q.size(), exp_ld_q.size());
        for (int x = 0; x < load_q.size() && x < exp_ld_q.size(); x++)
            chk($sformatf("%s_load%0d", tag, x), load_q[x], exp_ld_q[x]);
        chk({tag, "_starts"}, starts, exp_ld_q.size());
        chk({tag, "_words"}, got_q.size(), exp_q.size());
        for (int x = 0; x < got_q.size() && x < exp_q.size(); x++)
            chk($sformatf("%s_word%0d", tag, x), got_q[x], exp_q[x]);
        for (int x = 0; x < got_s_q.size() && x < exp_s_q.size(); x++)
            chk($sformatf("%s_satword%0d", tag, x), got_s_q[x], exp_s_q[x]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        load_q.delete();
        got_q.delete();
        got_s_q.delete();
        starts = 0;
    endtask

    task automatic set_parts(input vec_t v);
        c00 = v.p[0];
        c01 = v.p[1];
        c10 = v.p[2];
        c11 = v.p[3];
    endtask

    task automatic kick(input int n);
        num_tiles = 3'(n);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 3000; t++) begin
            if (done) begin
                done_cyc = cyc_n;
                done_err = err;
                return;
            end
            cyc();
        end
        fail_now({tag, "_done_timeout"});
    endtask

    task automatic wait_out_valid(input string tag);
        for (int t = 0; t < 200; t++) begin
            if (out_valid) return;
            cyc();
        end
        fail_now({tag, "_out_valid_timeout"});
    endtask

    // Full valid job: drive, wait for done, compare everything.
    task automatic run_valid(input vec_t v, input string tag);
        clear_logs();
        build_exp(v);
        set_parts(v);
        kick(v.n);
        wait_done(tag);
        chk({tag, "_err"}, done_err, 1'b0);
        chk({tag, "_done_lat"}, done_cyc, last_hs_cyc + 1);
        cyc();
        chk({tag, "_after"}, {done, busy}, 2'b00);
        compare_all(tag);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[8];
    vec_t v;
    logic [63:0] snap;

    initial begin
        vecs[0] = mk(1,    1,    2,    3,    4,    1,    2,    3,    4,    1,    2,    3,    4, 1'b0);
        vecs[1] = mk(2,    1,    1,    1,    1,    2,    2,    2,    2,    2,    2,    2,    2, 1'b0);
        vecs[2] = mk(3,   -1,    5,   -7,    0,   -3,   15,  -21,    0,   -3,   15,  -21,    0, 1'b0);
        vecs[3] = mk(4,   10,  -20,   30,  -40,   40,  -80,  120, -160,   40,  -80,  120, -160, 1'b0);
        vecs[4] = mk(3,  127,  127,  127,  127,  381,  381,  381,  381,  255,  255,  255,  255, 1'b0);
        vecs[5] = mk(3, -128, -128, -128, -128, -384, -384, -384, -384, -256, -256, -256, -256, 1'b0);
        vecs[6] = mk(0,    0,    0,    0,    0,    0,    0,    0,    0,    0,    0,    0,    0, 1'b1);
        vecs[7] = mk(5,    0,    0,    0,    0,    0,    0,    0,    0,    0,    0,    0,    0, 1'b1);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_tiles = '0;
        c00 = '0; c01 = '0; c10 = '0; c11 = '0;
        ld_ready = 1'b1; out_ready = 1'b1;
        repeat (3) cyc();
        chk("reset_outputs",
            {busy, done, err, ld_valid, mmu_start, out_valid, out_data, out_row, out_col,
             ld_a_row, ld_a_col, ld_b_row, ld_b_col}, '0);
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("idle_after_reset", {busy, done, ld_valid, out_valid}, 4'b0000);

        // Table-driven jobs.
        for (int t = 0; t < 8; t++) begin
            v = vecs[t];
            if (!v.er) begin
                run_valid(v, $sformatf("vec%0d", t));
            end else begin
                clear_logs();
                set_parts(v);
                chk($sformatf("vec%0d_busy_before", t), busy, 1'b0);
                kick(v.n);
                chk($sformatf("vec%0d_done_busy", t), {done, err, busy, ld_valid}, 4'b1110);
                cyc();
                chk($sformatf("vec%0d_after", t), {done, err, busy}, 3'b000);
                chk($sformatf("vec%0d_loads", t), load_q.size(), 0);
            end
        end

        // Output back-pressure: hold the first word for 5 cycles.
        v = mk(1, 5, 6, 7, 8, 5, 6, 7, 8, 5, 6, 7, 8, 1'b0);
        clear_logs();
        build_exp(v);
        set_parts(v);
        out_ready = 1'b0;
        kick(1);
        wait_out_valid("bp");
        snap = {1'b1, out_row, out_col, out_data};
        chk("bp_first", snap, {1'b1, 3'd0, 3'd0, 16'd5});
        for (int h = 0; h < 5; h++) begin
            cyc();
            chk($sformatf("bp_hold%0d", h), {out_valid, out_row, out_col, out_data}, snap);
        end
        out_ready = 1'b1;
        wait_done("bp");
        chk("bp_done_lat", done_cyc, last_hs_cyc + 1);
        cyc();
        compare_all("bp");

        // Load back-pressure on the second load of a 2-tile job.
        v = vecs[1];
        clear_logs();
        build_exp(v);
        set_parts(v);
        kick(2);
        for (int t = 0; t < 200; t++) begin
            if (ld_valid && load_q.size() == 1) break;
            cyc();
        end
        ld_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            cyc();
            chk($sformatf("ld_hold%0d", h),
                {ld_valid, mmu_start, ld_a_row, ld_a_col, ld_b_row, ld_b_col},
                {1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0});
        end
        ld_ready = 1'b1;
        wait_done("ldbp");
        cyc();
        compare_all("ldbp");

        // Abort while waiting on the second MMU computation.
        clear_logs();
        v = mk(2, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        set_parts(v);
        kick(2);
        for (int t = 0; t < 200; t++) begin
            if (mmu_start && starts == 1) break;
            cyc();
        end
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_compute_idle", {busy, done, ld_valid, mmu_start, out_valid}, 5'b0);
        for (int h = 0; h < 5; h++) begin
            cyc();
            chk($sformatf("abort_compute_quiet%0d", h), {busy, done}, 2'b00);
        end
        // Stray mmu_done while idle.
        c00 = 8'd100; c01 = 8'd100; c10 = 8'd100; c11 = 8'd100;
        inject_done = 1'b1;
        cyc();
        inject_done = 1'b0;
        chk("stray_done_idle", {busy, done, mmu_start}, 3'b000);
        run_valid(vecs[0], "post_abort1");

        // Abort on the cycle the first output word handshakes.
        clear_logs();
        v = mk(1, 9, 9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        set_parts(v);
        kick(1);
        wait_out_valid("abort_out");
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_out_idle", {busy, done, ld_valid, mmu_start, out_valid}, 5'b0);
        for (int h = 0; h < 3; h++) begin
            cyc();
            chk($sformatf("abort_out_quiet%0d", h), {busy, done}, 2'b00);
        end
        run_valid(vecs[0], "post_abort2");

        // Asynchronous reset mid-job, between clock edges.
        clear_logs();
        set_parts(vecs[1]);
        kick(2);
        repeat (5) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, done, ld_valid, mmu_start, out_valid}, 5'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        run_valid(vecs[0], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmu_tile_scheduler.md
Name: mmu_tile_scheduler

Overview:
- Sequences the 2x2 systolic MMU to compute an N x N product, N = 2*num_tiles, by looping over 2x2 tiles.
- For each output tile (i,j) it iterates k, requests the A(i,k)/B(k,j) tile load, starts the MMU and accumulates the four partial results.
- It streams each finished output tile through a valid/ready port.
- Sits between the host control unit and the memory/mmu_feeder pair.

Parameters:
- MAX_TILES, 4, largest tiles per matrix dimension.
- IDX_W, $clog2(MAX_TILES), width of tile indices.
- RES_W, 8, width of signed MMU partial results.
- ACC_W, 16, width of signed accumulators and output words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- num_tiles  in  IDX_W+1  tiles per dimension, sampled with start
- abort  in  1  synchronous abort
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  valid with done; high when num_tiles is 0 or greater than MAX_TILES
- ld_valid  out  1  tile load request
- ld_ready  in  1  memory accepts the load
- ld_a_row, ld_a_col  out  IDX_W each  A tile index (i,k)
- ld_b_row, ld_b_col  out  IDX_W each  B tile index (k,j)
- mmu_start  out  1  one-cycle compute launch
- mmu_done  in  1  one-cycle pulse; partials valid in the same cycle
- c00, c01, c10, c11  in  RES_W each  signed partial results
- out_valid  out  1  result word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  ACC_W  signed accumulated result
- out_row, out_col  out  IDX_W+1 each  element coordinates in the full matrix

Behaviour:
- Reset: state IDLE. All outputs 0. Counters and accumulators 0.
- States: IDLE, LOAD, LAUNCH, COMPUTE, ACCUM, DRAIN, FINISH.
- IDLE:
  - On start with a valid num_tiles: latch num_tiles, set i=j=k=0, go to LOAD.
  - On start with an invalid num_tiles: go to FINISH with err=1.
- LOAD:
  - ld_valid=1. Indices are driven from the counters and stay stable until the handshake.
  - ld_valid && ld_ready goes to LAUNCH. ld_valid drops the next cycle.
- LAUNCH: mmu_start=1 for exactly one cycle, then go to COMPUTE.
- COMPUTE:
  - Wait for mmu_done. On mmu_done, register c00..c11 and go to ACCUM.
  - mmu_done in any other state is ignored.
- ACCUM (one cycle):
  - Sign-extend each partial to ACC_W.
  - If k==0, acc = partial; otherwise acc = sat(acc + partial).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If k < num_tiles-1: k++, go to LOAD. Otherwise go to DRAIN.
- DRAIN:
  - Emit four words in order acc00, acc01, acc10, acc11.
  - out_row = 2i + r, out_col = 2j + c.
  - Each word is held stable while out_valid && !out_ready.
  - The word advances on out_valid && out_ready. out_valid stays high back-to-back when out_ready=1.
  - After the fourth handshake: k=0, then j++ (wrapping to 0 with i++).
  - If the last tile (i == j == num_tiles-1) is done, go to FINISH; otherwise go to LOAD.
- FINISH: done=1 for one cycle (err as determined), then go to IDLE. busy drops in the IDLE cycle.
- Loop order: i outer, j middle, k inner. Total loads = num_tiles^3.
- Latencies:
  - start to ld_valid: 1 cycle.
  - ld handshake to mmu_start: 1 cycle.
  - mmu_done to the next ld_valid (or to out_valid): 2 cycles (ACCUM, then LOAD/DRAIN).
- start while busy is ignored.
- abort in any non-IDLE state:
  - Next cycle is IDLE, with ld_valid, mmu_start and out_valid deasserted.
  - No done pulse. Accumulators are not cleared.
- abort has priority over every other event in the same cycle, including completed handshakes.
- rst_n low at any time: immediate return to reset values, regardless of the clock.

Decomposition:
- Shared package tpu_pkg holds:
  - the state enum;
  - localparams for default RES_W and ACC_W;
  - a sat_add function, reused by future accumulate paths.
- One natural sub-module, tile_accumulator:
  - four ACC_W registers with the k==0 load/saturating-add datapath and a drain-select mux;
  - the scheduler keeps only the FSM and counters.

Test Plan:
- num_tiles=1, partials {1,2,3,4}, out_ready=1 → one load (A(0,0), B(0,0)); outputs 1,2,3,4 at (0,0),(0,1),(1,0),(1,1); done 1 cycle after the last word; err=0.
- num_tiles=2, partials equal to 1 on every launch → 8 loads in order (i,j,k) = 000,001,010,011,100,101,110,111, with B index (k,j); every output = 2; 16 words with correct coordinates.
- Saturation, ACC_W=9, num_tiles=3 → all partials 127 give 255 (clamped from 381); all partials -128 give -256 (clamped from -384).
- Back-pressure: out_ready held low 5 cycles in DRAIN → out_data, out_row and out_col stable; no word lost or duplicated after release; ld_ready low 3 cycles → ld indices stable and mmu_start absent.
- num_tiles=0 and num_tiles=MAX_TILES+1 → no ld_valid; done and err high 1 cycle later; busy high only in that interval.
- abort asserted in COMPUTE, and separately during an out handshake → IDLE next cycle, no done; a later start with num_tiles=1 produces correct results from k==0 reload; a stray mmu_done while IDLE causes no effect.
